// File: rtl/pcie_vc_fifo_bank_if.sv
// Shared write/read/status bundle for the multi-VC TLP buffer.
// The master side is TLP assembly plus the VC arbiter, and the slave side is the buffer bank.
interface pcie_vc_fifo_bank_if #(
   parameter int DATA_WIDTH = 224,
   parameter int DEPTH      = 16,
   parameter int NUM_VC     = 4
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                      wr_en;
   logic [VC_W-1:0]           wr_vc;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic                      rd_en;
   logic [VC_W-1:0]           rd_vc;
   logic [DATA_WIDTH-1:0]     rd_data;
   logic                      rd_valid;
   logic [NUM_VC-1:0]         empty;
   logic [NUM_VC-1:0]         full;
   logic [NUM_VC-1:0]         almost_full;
   logic [NUM_VC*CNT_W-1:0]   count;
   logic                      err_clr;
   logic [NUM_VC-1:0]         overflow;
   logic [NUM_VC-1:0]         underflow;

   modport master (
      output wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
      input  rd_data, rd_valid, empty, full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_vc, wr_data, rd_en, rd_vc, err_clr,
      output rd_data, rd_valid, empty, full, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/pcie_vc_fifo_bank.sv
// NUM_VC independent TLP FIFOs that share one write port and one read port.
// Each VC keeps an explicit occupancy count, so all DEPTH slots are usable and DEPTH need not be a power of two.
module pcie_vc_fifo_bank #(
   parameter int DATA_WIDTH = 224,
   parameter int DEPTH      = 16,
   parameter int NUM_VC     = 4,
   parameter int AFULL_TH   = 12
) (
   input logic               clk,
   input logic               rst,
   pcie_vc_fifo_bank_if.slave bus
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [VC_W:0]      NUM_VC_L = (VC_W + 1)'(NUM_VC);
   localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   AFULL_C  = CNT_W'(AFULL_TH);
   localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0]   mem [NUM_VC][DEPTH];
   logic [PTR_W-1:0]        wr_ptr [NUM_VC];
   logic [PTR_W-1:0]        rd_ptr [NUM_VC];
   logic [CNT_W-1:0]        cnt [NUM_VC];

   logic [NUM_VC-1:0]       empty_v, full_v, afull_v;
   logic [NUM_VC*CNT_W-1:0] count_v;
   logic                    wr_vc_ok, rd_vc_ok, wr_acc, rd_acc;
   logic [NUM_VC-1:0]       wr_sel, rd_sel, ovf_sel, unf_sel;

   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    rd_valid_q;
   logic [NUM_VC-1:0]       ovf_q, unf_q;

   always_comb begin
      empty_v = '0;
      full_v  = '0;
      afull_v = '0;
      count_v = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         empty_v[v] = (cnt[v] == '0);
         full_v[v]  = (cnt[v] == DEPTH_C);
         afull_v[v] = (cnt[v] >= AFULL_C);
         count_v[v*CNT_W +: CNT_W] = cnt[v];
      end
   end

   // A write into a full VC can still be taken when the same VC is popped in this cycle.
   // An empty VC never forwards a same-cycle write to the read side.
   always_comb begin
      wr_vc_ok = ({1'b0, bus.wr_vc} < NUM_VC_L);
      rd_vc_ok = ({1'b0, bus.rd_vc} < NUM_VC_L);
      rd_acc   = bus.rd_en && rd_vc_ok && !empty_v[bus.rd_vc];
      wr_acc   = bus.wr_en && wr_vc_ok &&
                 (!full_v[bus.wr_vc] || (rd_acc && (bus.rd_vc == bus.wr_vc)));
      wr_sel   = '0;
      rd_sel   = '0;
      ovf_sel  = '0;
      unf_sel  = '0;
      if (wr_acc)
         wr_sel[bus.wr_vc] = 1'b1;
      if (rd_acc)
         rd_sel[bus.rd_vc] = 1'b1;
      if (bus.wr_en && wr_vc_ok && !wr_acc)
         ovf_sel[bus.wr_vc] = 1'b1;
      if (bus.rd_en && rd_vc_ok && !rd_acc)
         unf_sel[bus.rd_vc] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[bus.wr_vc][wr_ptr[bus.wr_vc]] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            cnt[v]    <= '0;
         end
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= '0;
         unf_q      <= '0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (wr_sel[v])
               wr_ptr[v] <= (wr_ptr[v] == PTR_LAST) ? '0 : wr_ptr[v] + 1'b1;
            if (rd_sel[v])
               rd_ptr[v] <= (rd_ptr[v] == PTR_LAST) ? '0 : rd_ptr[v] + 1'b1;
            if (wr_sel[v] && !rd_sel[v])
               cnt[v] <= cnt[v] + 1'b1;
            else if (rd_sel[v] && !wr_sel[v])
               cnt[v] <= cnt[v] - 1'b1;
         end
         rd_valid_q <= rd_acc;
         if (rd_acc)
            rd_data_q <= mem[bus.rd_vc][rd_ptr[bus.rd_vc]];
         // If a new error arrives in the same cycle as err_clr, the new error is kept.
         ovf_q <= (bus.err_clr ? '0 : ovf_q) | ovf_sel;
         unf_q <= (bus.err_clr ? '0 : unf_q) | unf_sel;
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.empty       = empty_v;
   assign bus.full        = full_v;
   assign bus.almost_full = afull_v;
   assign bus.count       = count_v;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
endmodule
